mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port among NUM_REQ requesters (icache fill, dcache miss/writeback, prefetcher) with one outstanding transaction at a time. The block performs round-robin arbitration, forwards the winner's request through a valid/ready handshake, holds the grant until the memory response returns, and routes that response back to the owner. It sits between the cache miss handlers and the memory bus interface.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, data/line-beat width
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clock)
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  response strobe to owner
- rsp_data  out  DATA_W  response data (broadcast; qualified by rsp_valid)
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_wr, mem_addr, mem_wdata  out  1, ADDR_W, DATA_W  forwarded payload
- mem_rsp_valid, mem_rsp_data  in  1, DATA_W  memory response (one per request, reads and writes)

## Operation
- FSM states IDLE, ISSUE, WAIT; reset state IDLE.
- IDLE: if any req_valid, pick winner via round-robin pointer `ptr` (index ptr highest priority, ascending mod NUM_REQ); register `owner`, go ISSUE. No req_valid: stay IDLE.
- ISSUE: mem_req_valid=1, payload muxed from req_*[owner]; req_ready[owner]=mem_req_ready, all other req_ready=0. On mem_req_valid&&mem_req_ready go WAIT.
- WAIT: mem_rsp_valid -> rsp_valid[owner]=1 same cycle, rsp_data=mem_rsp_data, ptr<=(owner+1) mod NUM_REQ, go IDLE.
- ptr changes only on response completion; reset value 0.
- Requesters hold req_valid and payload stable from assertion until req_ready; dropping valid in ISSUE is a protocol violation (bench asserts).
- mem_rsp_valid outside WAIT is ignored; rsp_valid stays 0.
- Reset mid-transaction: FSM to IDLE, ptr=0, owner=0, grant dropped; memory side is reset together, stale responses are not expected.

## Timing
- Reset values: req_ready=0, rsp_valid=0, mem_req_valid=0, mem_wr=0, mem_addr=0, mem_wdata=0, rsp_data=0 when rsp_valid=0.
- Arbitration latency 1 cycle: req_valid seen in IDLE at cycle t -> mem_req_valid at t+1.
- Response pass-through combinational (0 cycles); next arbitration in the cycle after the response, so back-to-back transactions are spaced at least 3 cycles.
- All outputs except rsp_valid/rsp_data/req_ready are registered-state functions only (no combinational path from req_valid to mem_req_valid).

## Configuration
- MEM_ARB_LOCK_EN defined: adds input req_lock[NUM_REQ]. If req_lock[owner]=1 in the response cycle, `locked` is set; the next IDLE grants only the owner (waits for its req_valid, others stall) and ptr is not advanced. locked clears when a transaction completes with req_lock[owner]=0. Used for AMO/LR-SC read-modify-write. Reset clears locked.
- Not defined: no req_lock port, no locked state, pure round-robin.

## Structure
- Package mem_arb_pkg: FSM state enum typedef, NUM_REQ bounds check constants, pointer width localparam ($clog2(NUM_REQ)).
- Sub-module mem_arb_rr_pick: combinational; inputs request vector and ptr, outputs one-hot grant and encoded index.

## Test plan
- Reset then req_valid=4'b0001, read addr 0x100 -> mem_req_valid at cycle 1 with mem_addr=0x100; response 0xDEAD -> rsp_valid=4'b0001, rsp_data=0xDEAD; ptr becomes 1.
- All four valid continuously, immediate memory -> owners served in order 0,1,2,3,0; no requester served twice before others.
- mem_req_ready held low 5 cycles in ISSUE -> payload stable, req_ready[owner]=0 throughout; accepted on cycle 6.
- Spurious mem_rsp_valid in IDLE and ISSUE -> no rsp_valid, state unchanged.
- reset asserted in WAIT -> outputs go to reset values immediately; after release req 2 valid -> granted, ptr restarted at 0.
- MEM_ARB_LOCK_EN: requester 1 completes with req_lock=1 while 0 and 2 valid -> next grant is 1 again; after unlocked completion, grant goes to 2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_REQ_MIN = 2;
  localparam int unsigned NUM_REQ_MAX = 8;
  localparam int unsigned PTR_W_MAX   = $clog2(NUM_REQ_MAX);

  // Width of a requester index / round-robin pointer for n requesters.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: index ptr_i has highest priority, then ascending mod NUM_REQ.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port, one outstanding transaction at a time.
// Optional MEM_ARB_LOCK_EN adds req_lock for back-to-back read-modify-write ownership.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_data
);

  localparam int unsigned PTR_W = ptr_w(NUM_REQ);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("mem_port_arbiter: NUM_REQ out of range");
  end

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
`ifdef MEM_ARB_LOCK_EN
  logic               locked_q, locked_d;
`endif
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  mem_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign pick_any = |pick_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
`ifdef MEM_ARB_LOCK_EN
      locked_q <= locked_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
`ifdef MEM_ARB_LOCK_EN
    locked_d = locked_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef MEM_ARB_LOCK_EN
        // A locked owner keeps the port; everyone else stalls until it re-requests.
        if (locked_q) begin
          if (req_valid[owner_q]) state_d = ST_ISSUE;
        end else if (pick_any) begin
          owner_d = pick_idx;
          state_d = ST_ISSUE;
        end
`else
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = ST_ISSUE;
        end
`endif
      end
      ST_ISSUE: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ST_IDLE;
`ifdef MEM_ARB_LOCK_EN
          locked_d = req_lock[owner_q];
          if (!req_lock[owner_q]) ptr_d = next_idx(owner_q);
`else
          ptr_d = next_idx(owner_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_data      = '0;
    mem_req_valid = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      ST_ISSUE: begin
        mem_req_valid      = 1'b1;
        mem_wr             = req_wr[owner_q];
        mem_addr           = req_addr[32'(owner_q)*ADDR_W +: ADDR_W];
        mem_wdata          = req_wdata[32'(owner_q)*DATA_W +: DATA_W];
        req_ready[owner_q] = mem_req_ready;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          rsp_valid[owner_q] = 1'b1;
          rsp_data           = mem_rsp_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a transaction-level round-robin model.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_wr, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
`ifdef MEM_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif
  logic [DW-1:0]   rsp_data, mem_wdata, mem_rsp_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_req_valid, mem_req_ready, mem_wr, mem_rsp_valid;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
`ifdef MEM_ARB_LOCK_EN
    .req_lock      (req_lock),
`endif
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending requests, their payloads and the fairness pointer.
  logic [N-1:0]  pend;
  logic [AW-1:0] p_addr [N];
  logic          p_wr   [N];
  logic [DW-1:0] p_wdata[N];
  int            ref_ptr;
  bit            locked;
  int            lock_owner;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic arm(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    pend[i]    = 1'b1;
    p_addr[i]  = a;
    p_wr[i]    = w;
    p_wdata[i] = d;
  endtask

  task automatic arm_rand(input int i);
    arm(i, $urandom, 1'($urandom), {$urandom, $urandom});
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = pend[i];
      req_wr[i]                = p_wr[i];
      req_addr[i*AW +: AW]     = p_addr[i];
      req_wdata[i*DW +: DW]    = p_wdata[i];
    end
  endtask

  function automatic int exp_winner();
    if (locked) return lock_owner;
    for (int k = 0; k < N; k++)
      if (pend[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    check_eq({tag, "_rsp_data"}, rsp_data, 0);
    check_eq({tag, "_mem_req_valid"}, 64'(mem_req_valid), 0);
    check_eq({tag, "_mem_wr"}, 64'(mem_wr), 0);
    check_eq({tag, "_mem_addr"}, 64'(mem_addr), 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
  task automatic run_txn(input int stall, input int rsp_dly, input bit lock_rsp,
                         input logic [DW-1:0] rdata, output int served);
    int w;
    w = exp_winner();
    served = w;
    if (w < 0) begin
      check_eq("txn_no_pending", 0, 1);
      return;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    drive_reqs();
    @(negedge clk);
    check_eq("idle_mem_req_valid", 64'(mem_req_valid), 0);
    check_eq("idle_req_ready", 64'(req_ready), 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'($urandom);
      mem_rsp_data  = {$urandom, $urandom};
      @(negedge clk);
      check_eq("stall_mem_req_valid", 64'(mem_req_valid), 1);
      check_eq("stall_mem_addr", 64'(mem_addr), 64'(p_addr[w]));
      check_eq("stall_mem_wr", 64'(mem_wr), 64'(p_wr[w]));
      check_eq("stall_mem_wdata", mem_wdata, p_wdata[w]);
      check_eq("stall_req_ready", 64'(req_ready), 0);
      check_eq("stall_spurious_rsp_valid", 64'(rsp_valid), 0);
      check_eq("stall_spurious_rsp_data", rsp_data, 0);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_eq("issue_mem_req_valid", 64'(mem_req_valid), 1);
    check_eq("issue_mem_addr", 64'(mem_addr), 64'(p_addr[w]));
    check_eq("issue_mem_wr", 64'(mem_wr), 64'(p_wr[w]));
    check_eq("issue_mem_wdata", mem_wdata, p_wdata[w]);
    check_eq("issue_req_ready", 64'(req_ready), 64'd1 << w);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    pend[w] = 1'b0;
    drive_reqs();
    for (int r = 0; r < rsp_dly; r++) begin
      @(negedge clk);
      check_eq("wait_mem_req_valid", 64'(mem_req_valid), 0);
      check_eq("wait_rsp_valid", 64'(rsp_valid), 0);
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
`ifdef MEM_ARB_LOCK_EN
    req_lock = lock_rsp ? N'(1 << w) : '0;
`endif
    @(negedge clk);
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1 << w);
    check_eq("rsp_data", rsp_data, rdata);
    check_eq("rsp_mem_req_valid", 64'(mem_req_valid), 0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    req_lock = '0;
`endif
    if (lock_rsp) begin
      locked     = 1'b1;
      lock_owner = w;
    end else begin
      locked  = 1'b0;
      ref_ptr = (w + 1) % N;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int served;
    int start;
    rst_n         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1234;
`ifdef MEM_ARB_LOCK_EN
    req_lock      = '0;
`endif
    pend = '0;
    for (int i = 0; i < N; i++) begin
      p_addr[i] = '0; p_wr[i] = 1'b0; p_wdata[i] = '0;
    end
    ref_ptr = 0; locked = 1'b0; lock_owner = 0;
    drive_reqs();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b0;

    // Single read from requester 0.
    arm(0, 32'h100, 1'b0, '0);
    run_txn(0, 0, 1'b0, 64'hDEAD, served);

    // Spurious memory response while idle.
    pend = '0;
    drive_reqs();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hBAD;
    @(negedge clk);
    check_eq("idle_spurious_rsp_valid", 64'(rsp_valid), 0);
    check_eq("idle_spurious_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("idle_spurious_mem_req_valid", 64'(mem_req_valid), 0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;

    // All requesters continuously valid: strict rotation.
    for (int i = 0; i < N; i++) arm_rand(i);
    start = ref_ptr;
    for (int k = 0; k < N + 1; k++) begin
      run_txn(0, 0, 1'b0, {$urandom, $urandom}, served);
      check_eq("rotation_order", 64'(served), 64'((start + k) % N));
      arm_rand(served);
    end

    // Five cycles of backpressure in ISSUE, accepted on the sixth.
    run_txn(5, 2, 1'b0, {$urandom, $urandom}, served);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && ($urandom % 2 == 0)) arm_rand(i);
      if (pend == '0) arm_rand($urandom % N);
      run_txn($urandom % 4, $urandom % 4, 1'b0, {$urandom, $urandom}, served);
    end

    // Reset while waiting for a response.
    pend = '0;
    arm(1, 32'hA5A5_0000, 1'b1, 64'h77);
    drive_reqs();
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    pend = '0;
    drive_reqs();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hCAFE;
    #2;
    check_eq("pre_reset_rsp_valid", 64'(rsp_valid), 64'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_wait");
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    rst_n = 1'b1;
    ref_ptr = 0; locked = 1'b0; lock_owner = 0;
    arm(2, 32'h2000, 1'b0, '0);
    arm(3, 32'h3000, 1'b1, 64'h33);
    run_txn(0, 1, 1'b0, 64'h5A5A, served);

`ifdef MEM_ARB_LOCK_EN
    // Lock keeps requester 1 as owner even with 0 and 2 waiting.
    pend = '0;
    arm(0, 32'h4000, 1'b0, '0);
    run_txn(0, 0, 1'b0, 64'h1, served);
    arm(0, 32'h4100, 1'b0, '0);
    arm(1, 32'h4200, 1'b0, '0);
    arm(2, 32'h4300, 1'b1, 64'h99);
    run_txn(0, 0, 1'b1, 64'h2, served);
    drive_reqs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("locked_stall_mem_req_valid", 64'(mem_req_valid), 0);
      @(posedge clk); #1;
    end
    arm(1, 32'h4400, 1'b1, 64'h44);
    run_txn(1, 0, 1'b0, 64'h3, served);
    run_txn(0, 0, 1'b0, 64'h4, served);
    check_eq("after_unlock_owner", 64'(served), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
